// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing receiver: lock FSM encoding, default counter widths
// and the nominal timing of the 12 MHz VGA generator this block is paired with.
package vga_pkg;

  localparam int unsigned DefHTimerBits = 9;
  localparam int unsigned DefVTimerBits = 9;

  localparam int unsigned NomLineClks   = 382;
  localparam int unsigned NomHsyncClks  = 46;
  localparam int unsigned NomFrameLines = 526;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop synchronizer for an asynchronous active-low sync pin plus edge detection on the
// synchronized level. Flops idle high so reset never creates a spurious falling edge.
module vga_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;
  assign fall_o  = ~sync_q & dly_q;

endmodule

// File: rtl/vga_timing_rx.sv
// Measures incoming VGA sync timing (line period, hsync width, frame length), tracks the
// raster position and reports lock once consecutive frames agree.
module vga_timing_rx
  import vga_pkg::*;
#(
  parameter int unsigned H_TIMER_BITS = DefHTimerBits,
  parameter int unsigned V_TIMER_BITS = DefVTimerBits,
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter int unsigned H_TOL        = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  output logic [H_TIMER_BITS:0] x,
  output logic [V_TIMER_BITS:0] y,
  output logic [H_TIMER_BITS:0] line_len,
  output logic [H_TIMER_BITS:0] hs_width,
  output logic [V_TIMER_BITS:0] frame_lines,
  output logic                  locked,
  output logic                  line_strobe,
  output logic                  frame_strobe,
  output logic                  err
);

  localparam int unsigned HW     = H_TIMER_BITS + 1;
  localparam int unsigned VW     = V_TIMER_BITS + 1;
  localparam int unsigned MatchW = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0]     XMax     = '1;
  localparam logic [HW-1:0]     XPreMax  = XMax - 1'b1;
  localparam logic [VW-1:0]     YMax     = '1;
  localparam logic [HW-1:0]     HTol     = HW'(H_TOL);
  localparam logic [MatchW-1:0] LockLast = MatchW'(LOCK_FRAMES - 1);

  logic h_level, h_rise, h_fall;
  logic v_level, v_rise, v_fall;
  logic unused_v;

  vga_sync_edge u_hsync (
    .CLK     (CLK),
    .RST     (RST),
    .async_i (hsync_in),
    .level_o (h_level),
    .rise_o  (h_rise),
    .fall_o  (h_fall)
  );

  vga_sync_edge u_vsync (
    .CLK     (CLK),
    .RST     (RST),
    .async_i (vsync_in),
    .level_o (v_level),
    .rise_o  (v_rise),
    .fall_o  (v_fall)
  );

  assign unused_v = v_level ^ v_rise;

  logic [HW-1:0] x_q, line_len_q, hs_cnt_q, hs_width_q;
  logic [VW-1:0] y_q, frame_lines_q;
  logic          line_strobe_q, frame_strobe_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q            <= '0;
      y_q            <= '0;
      line_len_q     <= '0;
      hs_cnt_q       <= '0;
      hs_width_q     <= '0;
      frame_lines_q  <= '0;
      line_strobe_q  <= 1'b0;
      frame_strobe_q <= 1'b0;
    end else begin
      line_strobe_q  <= h_fall;
      frame_strobe_q <= v_fall;

      if (h_fall) begin
        x_q        <= '0;
        line_len_q <= (x_q == XMax) ? XMax : x_q + 1'b1;
      end else if (x_q != XMax) begin
        x_q <= x_q + 1'b1;
      end

      // vsync wins over a coincident hsync for the line counter
      if (v_fall) begin
        y_q           <= '0;
        frame_lines_q <= (y_q == YMax) ? YMax : y_q + 1'b1;
      end else if (h_fall && (y_q != YMax)) begin
        y_q <= y_q + 1'b1;
      end

      if (h_rise) begin
        hs_width_q <= hs_cnt_q;
        hs_cnt_q   <= '0;
      end else if (!h_level && (hs_cnt_q != XMax)) begin
        hs_cnt_q <= hs_cnt_q + 1'b1;
      end
    end
  end

  // Fires only on the step into saturation, so a dead hsync gives a single err pulse.
  logic          x_hit;
  logic [HW-1:0] line_dev;

  vga_state_e        state_q;
  logic [HW-1:0]     ref_line_q;
  logic [VW-1:0]     ref_frame_q;
  logic [MatchW-1:0] match_q;
  logic              locked_q, err_q;

  always_comb begin
    x_hit    = !h_fall && (x_q == XPreMax);
    line_dev = (line_len_q >= ref_line_q) ? line_len_q - ref_line_q : ref_line_q - line_len_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StSearch;
      ref_line_q  <= '0;
      ref_frame_q <= '0;
      match_q     <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (x_hit) begin
        state_q  <= StSearch;
        match_q  <= '0;
        locked_q <= 1'b0;
        err_q    <= 1'b1;
      end else begin
        unique case (state_q)
          StSearch: begin
            if (frame_strobe_q) begin
              state_q     <= StMeasure;
              ref_line_q  <= line_len_q;
              ref_frame_q <= frame_lines_q;
              match_q     <= '0;
            end
          end
          StMeasure: begin
            if (frame_strobe_q) begin
              if ((line_len_q == ref_line_q) && (frame_lines_q == ref_frame_q)) begin
                if (match_q == LockLast) begin
                  state_q  <= StLocked;
                  locked_q <= 1'b1;
                  match_q  <= MatchW'(LOCK_FRAMES);
                end else begin
                  match_q <= match_q + 1'b1;
                end
              end else begin
                ref_line_q  <= line_len_q;
                ref_frame_q <= frame_lines_q;
                match_q     <= '0;
              end
            end
          end
          StLocked: begin
            if ((line_strobe_q && (line_dev > HTol)) ||
                (frame_strobe_q && (frame_lines_q != ref_frame_q))) begin
              state_q  <= StSearch;
              match_q  <= '0;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          default: begin
            state_q  <= StSearch;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign line_len     = line_len_q;
  assign hs_width     = hs_width_q;
  assign frame_lines  = frame_lines_q;
  assign locked       = locked_q;
  assign line_strobe  = line_strobe_q;
  assign frame_strobe = frame_strobe_q;
  assign err          = err_q;

endmodule
